// File: rtl/mem_access_ctrl_pkg.sv
// Shared types for the memory-stage controller: access sizes, FSM states, lane helpers.
// Misalignment trapping is built in when MEM_MISALIGN_TRAP_EN is defined.
package mem_access_ctrl_pkg;

  typedef logic [63:0] u64;
  typedef logic [7:0]  u8;
  typedef logic [2:0]  u3;

  typedef enum logic [1:0] {
    MSIZE1 = 2'd0,
    MSIZE2 = 2'd1,
    MSIZE4 = 2'd2,
    MSIZE8 = 2'd3
  } msize_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    DONE = 2'd3
  } mem_ctrl_state_t;

  function automatic u8 size_mask(msize_t s);
    case (s)
      MSIZE1:  return 8'h01;
      MSIZE2:  return 8'h03;
      MSIZE4:  return 8'h0F;
      default: return 8'hFF;
    endcase
  endfunction

  // Natural alignment: the offset bits covered by the access size must be zero.
  function automatic logic is_misaligned(u3 off, msize_t s);
    case (s)
      MSIZE2:  return off[0] != 1'b0;
      MSIZE4:  return off[1:0] != 2'b00;
      MSIZE8:  return off != 3'b000;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/mem_access_ctrl_if.sv
// Pipeline-side and bus-side signals of the memory-stage controller.
// master = the controller itself, slave = the pipeline/bus environment.
interface mem_access_ctrl_if
  import mem_access_ctrl_pkg::*;
#(
  parameter int ADDR_W = 64
);
  logic              req_valid;
  logic              req_write;
  logic [ADDR_W-1:0] req_addr;
  msize_t            req_msize;
  logic              req_unsigned;
  u64                req_wdata;
  logic              req_ready;

  logic              resp_valid;
  u64                resp_rdata;
  logic              resp_err;
  logic              resp_ack;
  logic              stall;

  logic              dreq_valid;
  logic [ADDR_W-1:0] dreq_addr;
  msize_t            dreq_size;
  u8                 dreq_strobe;
  u64                dreq_data;

  logic              dresp_addr_ok;
  logic              dresp_data_ok;
  u64                dresp_data;

  modport master (
    input  req_valid, req_write, req_addr, req_msize, req_unsigned, req_wdata,
    input  resp_ack, dresp_addr_ok, dresp_data_ok, dresp_data,
    output req_ready, resp_valid, resp_rdata, resp_err, stall,
    output dreq_valid, dreq_addr, dreq_size, dreq_strobe, dreq_data
  );

  modport slave (
    output req_valid, req_write, req_addr, req_msize, req_unsigned, req_wdata,
    output resp_ack, dresp_addr_ok, dresp_data_ok, dresp_data,
    input  req_ready, resp_valid, resp_rdata, resp_err, stall,
    input  dreq_valid, dreq_addr, dreq_size, dreq_strobe, dreq_data
  );

endinterface

// File: rtl/mem_access_ctrl_lane_align.sv
// Byte-lane steering: store strobe/data shifted into the 8-byte bus word, and
// load data pulled down from its lane and sign- or zero-extended.
module mem_lane_align
  import mem_access_ctrl_pkg::*;
(
  input  u3      off_i,
  input  msize_t size_i,
  input  logic   unsigned_i,
  input  u64     wdata_i,
  input  u64     raw_i,
  output u8      strobe_o,
  output u64     sdata_o,
  output u64     ldata_o
);

  u64 lane;

  assign strobe_o = size_mask(size_i) << off_i;
  assign sdata_o  = wdata_i << {off_i, 3'b000};
  assign lane     = raw_i >> {off_i, 3'b000};

  always_comb begin
    ldata_o = lane;
    case (size_i)
      MSIZE1:  ldata_o = unsigned_i ? 64'(lane[7:0])  : 64'(signed'(lane[7:0]));
      MSIZE2:  ldata_o = unsigned_i ? 64'(lane[15:0]) : 64'(signed'(lane[15:0]));
      MSIZE4:  ldata_o = unsigned_i ? 64'(lane[31:0]) : 64'(signed'(lane[31:0]));
      default: ldata_o = lane;
    endcase
  end

endmodule

// File: rtl/mem_access_ctrl.sv
// Memory-stage controller: one load/store at a time, IDLE -> REQ -> WAIT -> DONE.
// Define MEM_MISALIGN_TRAP_EN to trap misaligned ops without touching the bus.
module mem_access_ctrl
  import mem_access_ctrl_pkg::*;
#(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 64
)(
  input  logic              clk,
  input  logic              resetn,
  mem_access_ctrl_if.master bus
);

  mem_ctrl_state_t   state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  msize_t            size_q, size_d;
  logic              uns_q, uns_d;
  logic              write_q, write_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;

  logic accept, capture, trap;
  u8    strb;
  u64   sdata, ldata;

  assign accept  = (state_q == IDLE) && bus.req_valid;
  assign capture = ((state_q == REQ) && bus.dresp_addr_ok && bus.dresp_data_ok) ||
                   ((state_q == WAIT) && bus.dresp_data_ok);

`ifdef MEM_MISALIGN_TRAP_EN
  logic err_q;

  assign trap = is_misaligned(bus.req_addr[2:0], bus.req_msize);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)     err_q <= 1'b0;
    else if (accept) err_q <= trap;
  end

  assign bus.resp_err = (state_q == DONE) && err_q;
`else
  assign trap         = 1'b0;
  assign bus.resp_err = 1'b0;
`endif

  mem_lane_align u_align (
    .off_i      (addr_q[2:0]),
    .size_i     (size_q),
    .unsigned_i (uns_q),
    .wdata_i    (wdata_q),
    .raw_i      (bus.dresp_data),
    .strobe_o   (strb),
    .sdata_o    (sdata),
    .ldata_o    (ldata)
  );

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state_q <= IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (bus.req_valid) state_d = trap ? DONE : REQ;
      REQ: begin
        if (bus.dresp_addr_ok && bus.dresp_data_ok) state_d = DONE;
        else if (bus.dresp_addr_ok)                 state_d = WAIT;
      end
      WAIT:    if (bus.dresp_data_ok) state_d = DONE;
      DONE:    if (bus.resp_ack)      state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    bus.req_ready  = 1'b0;
    bus.stall      = 1'b0;
    bus.dreq_valid = 1'b0;
    bus.resp_valid = 1'b0;
    case (state_q)
      IDLE: begin
        bus.req_ready = 1'b1;
        bus.stall     = bus.req_valid;
      end
      REQ: begin
        bus.dreq_valid = 1'b1;
        bus.stall      = 1'b1;
      end
      WAIT: bus.stall = 1'b1;
      DONE: begin
        bus.resp_valid = 1'b1;
        bus.stall      = ~bus.resp_ack;
      end
      default: ;
    endcase
  end

  // Bus-facing fields come only from the latched op so they hold still until addr_ok.
  assign bus.dreq_addr   = addr_q;
  assign bus.dreq_size   = size_q;
  assign bus.dreq_strobe = write_q ? strb  : 8'h00;
  assign bus.dreq_data   = write_q ? sdata : '0;
  assign bus.resp_rdata  = (state_q == DONE) ? rdata_q : '0;

  always_comb begin
    addr_d  = addr_q;
    size_d  = size_q;
    uns_d   = uns_q;
    write_d = write_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    if (accept) begin
      addr_d  = bus.req_addr;
      size_d  = bus.req_msize;
      uns_d   = bus.req_unsigned;
      write_d = bus.req_write;
      wdata_d = bus.req_wdata;
      rdata_d = '0;
    end
    if (capture) rdata_d = write_q ? '0 : ldata;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      addr_q  <= '0;
      size_q  <= MSIZE1;
      uns_q   <= 1'b0;
      write_q <= 1'b0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      addr_q  <= addr_d;
      size_q  <= size_d;
      uns_q   <= uns_d;
      write_q <= write_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
    end
  end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed bench for mem_access_ctrl with a response scoreboard; expectations
// follow MEM_MISALIGN_TRAP_EN the same way the design does.
module tb_mem_access_ctrl
  import mem_access_ctrl_pkg::*;
;

  typedef struct {
    u64   rdata;
    logic err;
  } exp_t;

  logic clk = 1'b0;
  logic resetn;
  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];

  always #5 clk = ~clk;

  mem_access_ctrl_if #(.ADDR_W(64)) bus ();

  mem_access_ctrl #(.ADDR_W(64), .DATA_W(64)) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=0x%h expected=0x%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present an op for one cycle from IDLE, then scramble the live request fields.
  task automatic issue(input logic wr, input logic [63:0] a, input msize_t sz, input logic uns,
                       input u64 wd, input u64 exp_rd, input logic exp_err);
    check("req_ready_idle", bus.req_ready, 1);
    bus.req_valid    = 1'b1;
    bus.req_write    = wr;
    bus.req_addr     = a;
    bus.req_msize    = sz;
    bus.req_unsigned = uns;
    bus.req_wdata    = wd;
    #1;
    check("stall_idle_req", bus.stall, 1);
    sb.push_back('{rdata: exp_rd, err: exp_err});
    step();
    bus.req_valid    = 1'b0;
    bus.req_write    = ~wr;
    bus.req_addr     = 64'hFFFF_FFFF_FFFF_FFFF;
    bus.req_msize    = (sz == MSIZE8) ? MSIZE1 : MSIZE8;
    bus.req_unsigned = ~uns;
    bus.req_wdata    = 64'hA5A5_A5A5_A5A5_A5A5;
  endtask

  // Bus side: addr_ok after adly REQ cycles, data_ok ddly cycles after that.
  task automatic serve(input u64 raw, input int adly, input int ddly, input logic [63:0] ea,
                       input msize_t esz, input u8 estrb, input u64 edata);
    for (int c = 0; c <= adly; c++) begin
      bus.dresp_addr_ok = (c == adly);
      bus.dresp_data_ok = (c == adly) && (ddly == 0);
      bus.dresp_data    = raw;
      #1;
      check("dreq_valid_req", bus.dreq_valid, 1);
      check("dreq_addr", bus.dreq_addr, ea);
      check("dreq_size", 64'(bus.dreq_size), 64'(esz));
      check("dreq_strobe", 64'(bus.dreq_strobe), 64'(estrb));
      check("dreq_data", bus.dreq_data, edata);
      check("stall_req", bus.stall, 1);
      step();
    end
    bus.dresp_addr_ok = 1'b0;
    bus.dresp_data_ok = 1'b0;
    for (int c = 1; c <= ddly; c++) begin
      bus.dresp_data_ok = (c == ddly);
      #1;
      check("dreq_valid_wait", bus.dreq_valid, 0);
      check("stall_wait", bus.stall, 1);
      step();
    end
    bus.dresp_data_ok = 1'b0;
    bus.dresp_data    = 64'h0123_4567_89AB_CDEF;
  endtask

  // Pipeline side: observe DONE, hold it for hold cycles, then ack (optionally with a new req_valid).
  task automatic respond(input int hold, input logic next_req);
    exp_t e;
    int   n = 0;
    while (bus.resp_valid !== 1'b1 && n < 20) begin
      step();
      n++;
    end
    check("resp_valid", bus.resp_valid, 1);
    check("resp_latency", 64'(n), 0);
    check("sb_depth", 64'(sb.size()), 1);
    if (sb.size() != 0) begin
      e = sb.pop_front();
      check("resp_rdata", bus.resp_rdata, e.rdata);
      check("resp_err", bus.resp_err, e.err);
      for (int i = 0; i < hold; i++) begin
        step();
        check("hold_resp_valid", bus.resp_valid, 1);
        check("hold_stall", bus.stall, 1);
        check("hold_rdata", bus.resp_rdata, e.rdata);
      end
    end
    bus.resp_ack  = 1'b1;
    bus.req_valid = next_req;
    #1;
    check("stall_on_ack", bus.stall, 0);
    if (next_req) check("req_ready_done", bus.req_ready, 0);
    step();
    bus.resp_ack = 1'b0;
    check("resp_valid_after_ack", bus.resp_valid, 0);
    check("dreq_valid_after_ack", bus.dreq_valid, 0);
  endtask

  initial begin
    resetn            = 1'b0;
    bus.req_valid     = 1'b0;
    bus.req_write     = 1'b0;
    bus.req_addr      = '0;
    bus.req_msize     = MSIZE1;
    bus.req_unsigned  = 1'b0;
    bus.req_wdata     = '0;
    bus.resp_ack      = 1'b0;
    bus.dresp_addr_ok = 1'b0;
    bus.dresp_data_ok = 1'b0;
    bus.dresp_data    = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_dreq_valid", bus.dreq_valid, 0);
    check("rst_resp_valid", bus.resp_valid, 0);
    check("rst_resp_err", bus.resp_err, 0);
    check("rst_resp_rdata", bus.resp_rdata, 0);
    check("rst_stall", bus.stall, 0);
    check("rst_req_ready", bus.req_ready, 1);
    resetn = 1'b1;
    step();

    // LB signed, byte 3 = 0x00, bus answers at once
    issue(1'b0, 64'h1003, MSIZE1, 1'b0, 64'h0, 64'h0, 1'b0);
    serve(64'h0000_0080_0000_0000, 0, 0, 64'h1003, MSIZE1, 8'h00, 64'h0);
    respond(0, 1'b0);

    // LB signed, byte 3 = 0x80
    issue(1'b0, 64'h1003, MSIZE1, 1'b0, 64'h0, 64'hFFFF_FFFF_FFFF_FF80, 1'b0);
    serve(64'h0000_0000_8000_0000, 0, 0, 64'h1003, MSIZE1, 8'h00, 64'h0);
    respond(0, 1'b0);

    // LHU with slow addr_ok and data_ok
    issue(1'b0, 64'h2006, MSIZE2, 1'b1, 64'h0, 64'h0000_0000_0000_BEEF, 1'b0);
    serve(64'hBEEF_0000_0000_0000, 3, 2, 64'h2006, MSIZE2, 8'h00, 64'h0);
    respond(0, 1'b0);

    // LW signed from upper word
    issue(1'b0, 64'h2004, MSIZE4, 1'b0, 64'h0, 64'hFFFF_FFFF_8000_0001, 1'b0);
    serve(64'h8000_0001_0000_0000, 1, 0, 64'h2004, MSIZE4, 8'h00, 64'h0);
    respond(0, 1'b0);

    // SB at the top lane: strobe and data truncate to the word
    issue(1'b1, 64'h7007, MSIZE1, 1'b0, 64'h12A5, 64'h0, 1'b0);
    serve(64'hFFFF_FFFF_FFFF_FFFF, 0, 0, 64'h7007, MSIZE1, 8'h80, 64'hA500_0000_0000_0000);
    respond(0, 1'b0);

    // SW, DONE held 4 cycles, ack together with the next request
    issue(1'b1, 64'h3004, MSIZE4, 1'b0, 64'h1122_3344, 64'h0, 1'b0);
    serve(64'hDEAD_BEEF_DEAD_BEEF, 0, 1, 64'h3004, MSIZE4, 8'hF0, 64'h1122_3344_0000_0000);
    respond(4, 1'b1);

    // LD taken the cycle after the ack
    issue(1'b0, 64'h5000, MSIZE8, 1'b0, 64'h0, 64'h8877_6655_4433_2211, 1'b0);
    serve(64'h8877_6655_4433_2211, 0, 0, 64'h5000, MSIZE8, 8'h00, 64'h0);
    respond(0, 1'b0);

    // Misaligned LW
`ifdef MEM_MISALIGN_TRAP_EN
    issue(1'b0, 64'h4002, MSIZE4, 1'b0, 64'h0, 64'h0, 1'b1);
    check("trap_no_dreq", bus.dreq_valid, 0);
    respond(0, 1'b0);
`else
    issue(1'b0, 64'h4002, MSIZE4, 1'b0, 64'h0, 64'h0000_0000_0000_DEAD, 1'b0);
    serve(64'h0000_0000_DEAD_BEEF, 0, 0, 64'h4002, MSIZE4, 8'h00, 64'h0);
    respond(0, 1'b0);
`endif

    // Reset while waiting for data
    issue(1'b0, 64'h6000, MSIZE4, 1'b0, 64'h0, 64'h0, 1'b0);
    bus.dresp_addr_ok = 1'b1;
    step();
    bus.dresp_addr_ok = 1'b0;
    check("wait_stall", bus.stall, 1);
    resetn = 1'b0;
    #1;
    check("mid_rst_dreq_valid", bus.dreq_valid, 0);
    check("mid_rst_resp_valid", bus.resp_valid, 0);
    check("mid_rst_req_ready", bus.req_ready, 1);
    check("mid_rst_stall", bus.stall, 0);
    void'(sb.pop_back());
    bus.dresp_data_ok = 1'b1;
    bus.dresp_data    = 64'hFFFF_FFFF_FFFF_FFFF;
    step();
    step();
    resetn            = 1'b1;
    bus.dresp_data_ok = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      check("post_rst_resp_valid", bus.resp_valid, 0);
      check("post_rst_dreq_valid", bus.dreq_valid, 0);
    end

    // Recovery op after reset
    issue(1'b0, 64'h6001, MSIZE1, 1'b1, 64'h0, 64'h0000_0000_0000_00C3, 1'b0);
    serve(64'h0000_0000_0000_C300, 0, 0, 64'h6001, MSIZE1, 8'h00, 64'h0);
    respond(0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
